i2c_write_ctrl: RTL and testbench

I2C_WRITE_CTRL -- requirements
Module: i2c_write_ctrl

---
 rtl/i2c_write_ctrl_if.sv | 22 ++
 rtl/i2c_write_ctrl.sv | 158 +++++++++++++++
 tb/tb_i2c_write_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_write_ctrl_if.sv
// rtl/i2c_write_ctrl_if.sv - request/status and I2C line bundle for i2c_write_ctrl
interface i2c_write_ctrl_if;
   logic       start;
   logic [6:0] dev_addr;
   logic [7:0] wr_data;
   logic       sda_in;
   logic       scl_out;
   logic       sda_out;
   logic       busy;
   logic       done;
   logic       nack;

   modport master (
      output start, dev_addr, wr_data, sda_in,
      input  scl_out, sda_out, busy, done, nack
   );

   modport slave (
      input  start, dev_addr, wr_data, sda_in,
      output scl_out, sda_out, busy, done, nack
   );
endinterface

// File: rtl/i2c_write_ctrl.sv
// rtl/i2c_write_ctrl.sv - single-byte I2C write master (START, addr+W, ACK, data, ACK, STOP)
module i2c_write_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   i2c_write_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;
   logic [1:0] qtr_q, qtr_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       ack_q, ack_d;
   logic       nack_q, nack_d;
   logic       done_q, done_d;
   logic       tick;
   logic       slot_end;
   logic       scl;
   logic       sda;
   logic       bit_scl;

   assign tick     = (div_q == DIV_LAST);
   assign slot_end = tick && (qtr_q == 2'd3);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      qtr_d   = qtr_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      ack_d   = ack_q;
      nack_d  = nack_q;
      done_d  = 1'b0;
      if (state_q == S_IDLE) begin
         div_d = 8'd0;
         qtr_d = 2'd0;
         idx_d = 3'd0;
         if (bus.start) begin
            addr_d  = {bus.dev_addr, 1'b0};
            data_d  = bus.wr_data;
            nack_d  = 1'b0;
            state_d = S_START;
         end
      end else begin
         div_d = tick ? 8'd0 : div_q + 8'd1;
         if (tick) begin
            qtr_d = qtr_q + 2'd1;
         end
         // Sample the acknowledge on the final clk of the SCL-high window
         if ((state_q == S_ACK1 || state_q == S_ACK2) && tick && qtr_q == 2'd2) begin
            ack_d = bus.sda_in;
         end
         if (slot_end) begin
            case (state_q)
               S_START: state_d = S_ADDR;
               S_ADDR: begin
                  idx_d = idx_q + 3'd1;
                  if (idx_q == 3'd7) state_d = S_ACK1;
               end
               S_ACK1: begin
                  if (ack_q) begin
                     nack_d  = 1'b1;
                     state_d = S_STOP;
                  end else begin
                     state_d = S_DATA;
                  end
               end
               S_DATA: begin
                  idx_d = idx_q + 3'd1;
                  if (idx_q == 3'd7) state_d = S_ACK2;
               end
               S_ACK2: begin
                  if (ack_q) nack_d = 1'b1;
                  state_d = S_STOP;
               end
               S_STOP: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         div_q   <= 8'd0;
         qtr_q   <= 2'd0;
         idx_q   <= 3'd0;
         addr_q  <= 8'd0;
         data_q  <= 8'd0;
         ack_q   <= 1'b0;
         nack_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         qtr_q   <= qtr_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         ack_q   <= ack_d;
         nack_q  <= nack_d;
         done_q  <= done_d;
      end
   end

   // Line levels come only from flops so start/sda_in never reach the pins combinationally
   assign bit_scl = (qtr_q == 2'd1) || (qtr_q == 2'd2);

   always_comb begin
      scl = 1'b1;
      sda = 1'b1;
      case (state_q)
         S_START: begin
            scl = (qtr_q != 2'd3);
            sda = (qtr_q < 2'd2);
         end
         S_ADDR: begin
            scl = bit_scl;
            sda = addr_q[3'd7 - idx_q];
         end
         S_DATA: begin
            scl = bit_scl;
            sda = data_q[3'd7 - idx_q];
         end
         S_ACK1, S_ACK2: begin
            scl = bit_scl;
            sda = 1'b1;
         end
         S_STOP: begin
            scl = (qtr_q != 2'd0);
            sda = (qtr_q >= 2'd2);
         end
         default: begin
            scl = 1'b1;
            sda = 1'b1;
         end
      endcase
   end

   assign bus.scl_out = scl;
   assign bus.sda_out = sda;
   assign bus.busy    = (state_q != S_IDLE);
   assign bus.done    = done_q;
   assign bus.nack    = nack_q;
endmodule

// File: tb/tb_i2c_write_ctrl.sv
// tb/tb_i2c_write_ctrl.sv - self-checking bench for i2c_write_ctrl
module tb_i2c_write_ctrl;
   localparam int CLK_DIV = 4;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   i2c_write_ctrl_if bus ();

   i2c_write_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] a;
      logic [7:0] d;
      logic       k1;
      logic       k2;
      logic [7:0] eab;
      logic [7:0] edb;
      int         ecyc;
      logic       enack;
      int         erises;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n, input logic exp_nack);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(!bus.busy && !bus.done && bus.scl_out && bus.sda_out, "idle_lines",
             {bus.busy, bus.done, bus.scl_out, bus.sda_out}, 4'b0011);
      end
      chk(bus.nack == exp_nack, "nack_hold", bus.nack, exp_nack);
   endtask

   // Returns at the negedge where done is seen, so the caller may start again in that cycle
   task automatic do_txn(input logic [6:0] a, input logic [7:0] d, input logic k1, input logic k2,
                         input logic spam, input logic [7:0] exp_ab, input logic [7:0] exp_db,
                         input int exp_cyc, input logic exp_nack, input int exp_rises,
                         input string name);
      logic [7:0] ab, db;
      logic       pscl, psda, got;
      int         rises, busy_cnt, starts, stops, bad_lvl, done_at;
      ab = 8'd0; db = 8'd0; rises = 0; busy_cnt = 0; starts = 0; stops = 0;
      bad_lvl = 0; done_at = 0; got = 1'b0;
      bus.dev_addr = a;
      bus.wr_data  = d;
      bus.start    = 1'b1;
      bus.sda_in   = k1;
      pscl = bus.scl_out;
      psda = bus.sda_out;
      @(posedge clk);
      @(negedge clk);
      if (spam) begin
         bus.wr_data  = 8'h3C;
         bus.dev_addr = 7'h11;
      end else begin
         bus.start = 1'b0;
      end
      chk(bus.busy && !bus.done && !bus.nack && bus.scl_out && bus.sda_out,
          {name, "_first_cycle"},
          {bus.busy, bus.done, bus.nack, bus.scl_out, bus.sda_out}, 5'b10011);
      for (int k = 1; k <= 2000; k++) begin
         if (k > 1) @(negedge clk);
         if (!pscl && bus.scl_out) begin
            if (rises < 8) ab = {ab[6:0], bus.sda_out};
            else if (rises >= 9 && rises < 17) db = {db[6:0], bus.sda_out};
            if ((rises == 8 || rises == 17) && !bus.sda_out) bad_lvl++;
            if (rises == exp_rises - 1 && bus.sda_out) bad_lvl++;
            rises++;
         end
         if (pscl && bus.scl_out && psda && !bus.sda_out) starts++;
         if (pscl && bus.scl_out && !psda && bus.sda_out) stops++;
         pscl = bus.scl_out;
         psda = bus.sda_out;
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            got = 1'b1;
            done_at = k;
            break;
         end
         if (spam && busy_cnt == 100) bus.start = 1'b0;
         bus.sda_in = (rises <= 9) ? k1 : k2;
      end
      bus.start = 1'b0;
      chk(got, {name, "_done_seen"}, got, 1);
      if (!got) return;
      chk(busy_cnt == exp_cyc, {name, "_busy_cycles"}, busy_cnt, exp_cyc);
      chk(done_at == exp_cyc + 1, {name, "_done_time"}, done_at, exp_cyc + 1);
      chk(bus.nack == exp_nack && !bus.busy, {name, "_nack"}, {bus.busy, bus.nack}, {1'b0, exp_nack});
      chk(ab == exp_ab, {name, "_addr_byte"}, ab, exp_ab);
      if (exp_rises == 19) chk(db == exp_db, {name, "_data_byte"}, db, exp_db);
      chk(rises == exp_rises, {name, "_scl_rises"}, rises, exp_rises);
      chk(starts == 1 && stops == 1, {name, "_start_stop"}, {starts[15:0], stops[15:0]}, 32'h0001_0001);
      chk(bad_lvl == 0, {name, "_ack_stop_levels"}, bad_lvl, 0);
   endtask

   initial begin
      logic [6:0] ra;
      logic [7:0] rd;
      logic       rk1, rk2;
      logic       pscl;
      int         rises, dones;
      checks   = 0;
      failures = 0;
      bus.start    = 1'b0;
      bus.dev_addr = 7'd0;
      bus.wr_data  = 8'd0;
      bus.sda_in   = 1'b1;
      reset        = 1'b0;

      tbl[0] = '{7'h50, 8'hA5, 1'b0, 1'b0, 8'hA0, 8'hA5, 320, 1'b0, 19};
      tbl[1] = '{7'h50, 8'hA5, 1'b1, 1'b0, 8'hA0, 8'h00, 176, 1'b1, 10};
      tbl[2] = '{7'h50, 8'hA5, 1'b0, 1'b1, 8'hA0, 8'hA5, 320, 1'b1, 19};
      tbl[3] = '{7'h7F, 8'h00, 1'b0, 1'b0, 8'hFE, 8'h00, 320, 1'b0, 19};
      tbl[4] = '{7'h01, 8'hFF, 1'b1, 1'b1, 8'h02, 8'h00, 176, 1'b1, 10};

      #23;
      chk(bus.scl_out && bus.sda_out && !bus.busy && !bus.done && !bus.nack, "reset_outputs",
          {bus.scl_out, bus.sda_out, bus.busy, bus.done, bus.nack}, 5'b11000);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 5; i++) begin
         do_txn(tbl[i].a, tbl[i].d, tbl[i].k1, tbl[i].k2, 1'b0, tbl[i].eab, tbl[i].edb,
                tbl[i].ecyc, tbl[i].enack, tbl[i].erises, $sformatf("vec%0d", i));
         idle(3, tbl[i].enack);
      end

      do_txn(7'h50, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA0, 8'hA5, 320, 1'b0, 19, "busy_start");
      idle(2, 1'b0);

      do_txn(7'h22, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h44, 8'h00, 176, 1'b1, 10, "b2b_first");
      do_txn(7'h33, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h66, 8'hC3, 320, 1'b0, 19, "b2b_second");
      idle(2, 1'b0);

      bus.dev_addr = 7'h50;
      bus.wr_data  = 8'hA5;
      bus.sda_in   = 1'b0;
      bus.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      rises = 0;
      pscl  = bus.scl_out;
      for (int k = 0; k < 2000 && rises < 13; k++) begin
         @(negedge clk);
         if (!pscl && bus.scl_out) rises++;
         pscl = bus.scl_out;
      end
      chk(rises == 13 && bus.busy, "midrst_reached_data_bit3", rises, 13);
      #2 reset = 1'b0;
      #1;
      chk(bus.scl_out && bus.sda_out && !bus.busy && !bus.done && !bus.nack, "midrst_released",
          {bus.scl_out, bus.sda_out, bus.busy, bus.done, bus.nack}, 5'b11000);
      dones = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      chk(dones == 0, "midrst_no_done", dones, 0);
      reset = 1'b1;
      do_txn(7'h50, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA0, 8'hA5, 320, 1'b0, 19, "after_reset");
      idle(2, 1'b0);

      for (int i = 0; i < 20; i++) begin
         ra  = 7'($urandom);
         rd  = 8'($urandom);
         rk1 = ($urandom_range(0, 3) == 0);
         rk2 = 1'($urandom);
         // Reference: address byte is the 7-bit address with W=0 appended; an address
         // NACK cuts the frame to START + 8 address + ACK + STOP slots.
         do_txn(ra, rd, rk1, rk2, 1'b0, {ra, 1'b0}, rd,
                (rk1 ? 11 : 20) * 4 * CLK_DIV, rk1 | rk2, rk1 ? 10 : 19,
                $sformatf("rand%0d", i));
         if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 2), rk1 | rk2);
      end
      idle(2, bus.nack);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
